wb_mtimer: RTL and testbench

//  RISC-V machine timer (mtime/mtimecmp) as a Wishbone classic slave on the shared bus.

---
 rtl/wb_mtimer.sv | 179 +++++++++++++++++
 tb/tb_wb_mtimer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_mtimer.sv
// -----------------------------------------------------------------------------
// wb_mtimer -- RISC-V machine timer (mtime / mtimecmp) as a Wishbone classic
// slave. Its irq_timer output feeds the core's timer interrupt input.
//
// Only adr[4:2] is decoded; the interconnect owns the base address and the
// window size.
//
// Register map (byte offset):
//   0x00 MTIME_LO     RW
//   0x04 MTIME_HI     RW
//   0x08 MTIMECMP_LO  RW
//   0x0C MTIMECMP_HI  RW
//   0x10 CTRL         RW  bit0 = EN, other bits read 0
//   other offsets     read 0, writes ignored, still acked
//
// Parameters:
//   PRESCALE  clk cycles per mtime increment, 1..65536
//   CMP_RST   reset value of mtimecmp (all-ones: no interrupt after reset)
//
// Optional feature (compile-time macro WB_MTIMER_SNAPSHOT_EN):
//   A read of MTIME_LO latches mtime[63:32] into a shadow register, and reads
//   of MTIME_HI return that shadow. This gives tear-free lo-then-hi reads. A
//   write to MTIME_HI also loads the shadow. Without the macro, MTIME_HI
//   reads the live counter and no shadow register exists.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   wb_adr     word address bits [4:2]
//   wb_dat_i   write data
//   wb_sel     byte enables for writes
//   wb_we      write enable
//   wb_cyc     bus cycle
//   wb_stb     strobe
//   wb_ack     acknowledge
//   wb_err     error, tied 0
//   wb_dat_o   read data, zero whenever wb_ack is low
//   irq_timer  level interrupt, registered: en && (mtime >= mtimecmp)
//
// Handshake: a request is cyc&stb while ack is low. ack is registered and
// rises the cycle after the request. It stays high for exactly one cycle, so
// back-to-back requests are acked every second cycle. A write commits on the
// ack cycle, using the address, data and sel held during that cycle.
// -----------------------------------------------------------------------------
module wb_mtimer #(
  parameter int unsigned PRESCALE = 1,
  parameter logic [63:0] CMP_RST  = '1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:2]  wb_adr,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel,
  input  logic        wb_we,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic        wb_ack,
  output logic        wb_err,
  output logic [31:0] wb_dat_o,
  output logic        irq_timer
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  localparam logic [2:0] A_MTIME_LO = 3'd0;
  localparam logic [2:0] A_MTIME_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO   = 3'd2;
  localparam logic [2:0] A_CMP_HI   = 3'd3;
  localparam logic [2:0] A_CTRL     = 3'd4;

  logic [63:0]   mtime, mtime_inc, mtime_nxt;
  logic [63:0]   mtimecmp, mtimecmp_nxt;
  logic          en, en_nxt;
  logic [PW-1:0] ps_cnt, ps_cnt_nxt;
  logic          tick;
  logic          wb_req, wr_commit;
  logic [31:0]   rd_data;
  logic [31:0]   mtime_hi_rd;

  // Replace only the bytes selected by be.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  assign wb_err    = 1'b0;
  assign wb_req    = wb_cyc && wb_stb && !wb_ack;
  assign wr_commit = wb_cyc && wb_stb && wb_ack && wb_we;

  // The prescaler holds its value while disabled, so re-enabling the timer
  // resumes the interval where it stopped.
  assign tick      = en && (ps_cnt == PS_MAX);
  assign mtime_inc = tick ? mtime + 64'd1 : mtime;

  always_comb begin
    ps_cnt_nxt   = ps_cnt;
    mtime_nxt    = mtime_inc;
    mtimecmp_nxt = mtimecmp;
    en_nxt       = en;
    if (en) begin
      ps_cnt_nxt = tick ? '0 : ps_cnt + PW'(1);
    end
    // Writes are merged over the incremented value. On a tick cycle, the
    // unwritten bytes still advance. A half-word write never carries into
    // the other half.
    if (wr_commit) begin
      case (wb_adr)
        A_MTIME_LO: mtime_nxt[31:0]     = merge_bytes(mtime_inc[31:0], wb_dat_i, wb_sel);
        A_MTIME_HI: mtime_nxt[63:32]    = merge_bytes(mtime_inc[63:32], wb_dat_i, wb_sel);
        A_CMP_LO:   mtimecmp_nxt[31:0]  = merge_bytes(mtimecmp[31:0], wb_dat_i, wb_sel);
        A_CMP_HI:   mtimecmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], wb_dat_i, wb_sel);
        A_CTRL:     if (wb_sel[0]) en_nxt = wb_dat_i[0];
        default:    ;
      endcase
    end
  end

`ifdef WB_MTIMER_SNAPSHOT_EN
  logic [31:0] mtime_hi_shadow;

  // The shadow is loaded in the same cycle that MTIME_LO read data is
  // captured, so a lo-then-hi pair returns one coherent 64-bit value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_hi_shadow <= '0;
    end else if (wb_req && !wb_we && (wb_adr == A_MTIME_LO)) begin
      mtime_hi_shadow <= mtime[63:32];
    end else if (wr_commit && (wb_adr == A_MTIME_HI)) begin
      mtime_hi_shadow <= mtime_nxt[63:32];
    end
  end

  assign mtime_hi_rd = mtime_hi_shadow;
`else
  assign mtime_hi_rd = mtime[63:32];
`endif

  always_comb begin
    rd_data = '0;
    case (wb_adr)
      A_MTIME_LO: rd_data = mtime[31:0];
      A_MTIME_HI: rd_data = mtime_hi_rd;
      A_CMP_LO:   rd_data = mtimecmp[31:0];
      A_CMP_HI:   rd_data = mtimecmp[63:32];
      A_CTRL:     rd_data = {31'd0, en};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime     <= '0;
      mtimecmp  <= CMP_RST;
      en        <= 1'b1;
      ps_cnt    <= '0;
      wb_ack    <= 1'b0;
      wb_dat_o  <= '0;
      irq_timer <= 1'b0;
    end else begin
      mtime     <= mtime_nxt;
      mtimecmp  <= mtimecmp_nxt;
      en        <= en_nxt;
      ps_cnt    <= ps_cnt_nxt;
      wb_ack    <= wb_req;
      // Read data is captured with the request, so it is present only
      // during the ack cycle and is zero otherwise.
      wb_dat_o  <= wb_req ? rd_data : '0;
      // Registered compare: the interrupt reflects the previous cycle's state.
      irq_timer <= en && (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_wb_mtimer.sv
// -----------------------------------------------------------------------------
// tb_wb_mtimer -- directed bench for wb_mtimer.
// Instance u1 has PRESCALE=1 and instance u4 has PRESCALE=4. The two
// instances share the address, data, sel and we lines, but each has its own
// cyc/stb. u4 also has its own reset.
// Expected read data is pushed to exp_q when a read is issued. It is popped
// and compared when the DUT acks.
// -----------------------------------------------------------------------------
module tb_wb_mtimer;

  localparam logic [2:0] R_MLO  = 3'd0;
  localparam logic [2:0] R_MHI  = 3'd1;
  localparam logic [2:0] R_CLO  = 3'd2;
  localparam logic [2:0] R_CHI  = 3'd3;
  localparam logic [2:0] R_CTRL = 3'd4;
  localparam logic [2:0] R_HOLE = 3'd6;  // byte offset 0x18

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst  = 1'b1;
  logic rst4 = 1'b1;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // bus
  logic [2:0]  adr   = '0;
  logic [31:0] dat_w = '0;
  logic [3:0]  sel   = '0;
  logic        we    = 1'b0;
  logic        cyc1 = 1'b0, stb1 = 1'b0, cyc4 = 1'b0, stb4 = 1'b0;
  logic        ack1, err1, irq1, ack4, err4, irq4;
  logic [31:0] dat1, dat4;

  wb_mtimer #(.PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .wb_adr(adr), .wb_dat_i(dat_w), .wb_sel(sel),
    .wb_we(we), .wb_cyc(cyc1), .wb_stb(stb1), .wb_ack(ack1), .wb_err(err1),
    .wb_dat_o(dat1), .irq_timer(irq1)
  );

  wb_mtimer #(.PRESCALE(4)) u4 (
    .clk(clk), .rst(rst4), .wb_adr(adr), .wb_dat_i(dat_w), .wb_sel(sel),
    .wb_we(we), .wb_cyc(cyc4), .wb_stb(stb4), .wb_ack(ack4), .wb_err(err4),
    .wb_dat_o(dat4), .irq_timer(irq4)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned commit_edge = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One classic transaction. Signals are held through the ack cycle and
  // dropped just after the edge that commits a write.
  task automatic xfer(input bit tgt, input bit w, input logic [2:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd);
    bit got;
    got = 1'b0;
    rd  = '0;
    adr = a; dat_w = d; sel = s; we = w;
    if (tgt) begin cyc4 = 1'b1; stb4 = 1'b1; end
    else     begin cyc1 = 1'b1; stb1 = 1'b1; end
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if ((tgt ? ack4 : ack1) === 1'b1) begin
        got = 1'b1;
        rd  = tgt ? dat4 : dat1;
      end
    end
    check("ack_seen", {63'd0, got}, 64'd1);
    if (got) begin
      @(posedge clk); #1;
      commit_edge = edge_n;
      check("ack_one_cycle", {63'd0, (tgt ? ack4 : ack1)}, 64'd0);
    end
    cyc1 = 1'b0; stb1 = 1'b0; cyc4 = 1'b0; stb4 = 1'b0; we = 1'b0; sel = '0;
  endtask

  task automatic wr(input bit tgt, input logic [2:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] unused_rd;
    xfer(tgt, 1'b1, a, d, s, unused_rd);
  endtask

  task automatic rd(input bit tgt, input logic [2:0] a, input logic [31:0] exp,
                    input string tag);
    logic [31:0] got_d;
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    xfer(tgt, 1'b0, a, 32'd0, 4'h0, got_d);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, {32'd0, got_d}, {32'd0, e});
  endtask

  initial begin
    int unsigned t0;
    bit rose;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {63'd0, ack1}, 64'd0);
    check("rst_dat", {32'd0, dat1}, 64'd0);
    check("rst_err", {63'd0, err1}, 64'd0);
    check("rst_irq", {63'd0, irq1}, 64'd0);
    check("rst_irq4", {63'd0, irq4}, 64'd0);
    rst = 1'b0; rst4 = 1'b0;

    // free-running count from reset, compare reset value
    repeat (10) @(posedge clk);
    #1;
    rd(0, R_MLO, 32'd10, "mtime_after_10");
    rd(0, R_CHI, 32'hFFFF_FFFF, "cmp_hi_reset");
    check("irq_idle", {63'd0, irq1}, 64'd0);

    // irq rises one cycle after mtime reaches mtimecmp
    wr(0, R_MLO, 32'd0, 4'hF);
    t0 = commit_edge;
    wr(0, R_CLO, 32'h20, 4'hF);
    wr(0, R_CHI, 32'h0, 4'hF);
    check("irq_before_match", {63'd0, irq1}, 64'd0);
    rose = 1'b0;
    for (int i = 0; i < 60 && !rose; i++) begin
      @(posedge clk); #1;
      if (irq1 === 1'b1) rose = 1'b1;
    end
    check("irq_rose", {63'd0, rose}, 64'd1);
    check("irq_rise_cycle", {32'd0, edge_n - t0}, 64'd33);
    wr(0, R_CLO, 32'h1000, 4'hF);
    check("irq_hold_on_commit", {63'd0, irq1}, 64'd1);
    @(posedge clk); #1;
    check("irq_cleared", {63'd0, irq1}, 64'd0);

    // 64-bit carry, half writes independent, EN=0 on a tick keeps the tick
    wr(0, R_CTRL, 32'd0, 4'hF);
    wr(0, R_MHI, 32'd5, 4'hF);
    wr(0, R_MLO, 32'hFFFF_FFFE, 4'hF);
    rd(0, R_MHI, 32'd5, "lo_write_keeps_hi");
    rd(0, R_MLO, 32'hFFFF_FFFE, "frozen_lo");
    wr(0, R_MHI, 32'd0, 4'hF);
    wr(0, R_CTRL, 32'd1, 4'hF);
    wr(0, R_CTRL, 32'd0, 4'hF);
    rd(0, R_MLO, 32'd0, "carry_lo");
    rd(0, R_MHI, 32'd1, "carry_hi");
    wr(0, R_CTRL, 32'd1, 4'hF);

    // byte enables, unmapped offset, CTRL read mask
    wr(0, R_CLO, 32'h1122_3344, 4'hF);
    wr(0, R_CLO, 32'hAABB_CCDD, 4'b0010);
    rd(0, R_CLO, 32'h1122_CC44, "sel_byte1");
    rd(0, R_CHI, 32'h0, "cmp_hi_written");
    wr(0, R_HOLE, 32'hDEAD_BEEF, 4'hF);
    rd(0, R_HOLE, 32'd0, "hole_reads_0");
    wr(0, R_CTRL, 32'hFFFF_FFFF, 4'hF);
    rd(0, R_CTRL, 32'd1, "ctrl_mask");

    // snapshot read: mtime = 1_FFFFFFFF, read lo, wait, read hi
    wr(0, R_CTRL, 32'd0, 4'hF);
    wr(0, R_MLO, 32'hFFFF_FFFF, 4'hF);
    wr(0, R_MHI, 32'd1, 4'hF);
    wr(0, R_CTRL, 32'd1, 4'hF);
    rd(0, R_MLO, 32'hFFFF_FFFF, "snap_lo");
    repeat (5) @(posedge clk);
    #1;
`ifdef WB_MTIMER_SNAPSHOT_EN
    rd(0, R_MHI, 32'd1, "snap_hi");
`else
    rd(0, R_MHI, 32'd2, "live_hi");
`endif

    // PRESCALE=4: freeze, resume from the frozen prescale count, merge on a tick
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    wr(1, R_CTRL, 32'd0, 4'hF);          // prescale count frozen at 2
    wr(1, R_MLO, 32'h100, 4'hF);
    repeat (20) @(posedge clk);
    #1;
    rd(1, R_MLO, 32'h100, "p4_frozen");
    wr(1, R_CTRL, 32'd1, 4'hF);          // enable at edge A; ticks at A+2, A+6, ...
    repeat (9) @(posedge clk);
    #1;
    rd(1, R_MLO, 32'h102, "p4_rate");
    @(posedge clk); #1;
    wr(1, R_MLO, 32'h0000_5500, 4'b0010); // commits on tick edge A+14
    rd(1, R_MLO, 32'h0000_5504, "p4_tick_merge");

    // reset on the ack cycle discards the write
    adr = R_CLO; dat_w = 32'd5; sel = 4'hF; we = 1'b1; cyc4 = 1'b1; stb4 = 1'b1;
    @(posedge clk); #1;
    check("rst_on_ack_ack_high", {63'd0, ack4}, 64'd1);
    rst4 = 1'b1;
    @(posedge clk); #1;
    check("rst_on_ack_dropped", {63'd0, ack4}, 64'd0);
    rst4 = 1'b0; cyc4 = 1'b0; stb4 = 1'b0; we = 1'b0; sel = '0;
    rd(1, R_CLO, 32'hFFFF_FFFF, "rst_discards_write");
    rd(1, R_CTRL, 32'd1, "rst_en_back");

    check("scoreboard_empty", {32'd0, exp_q.size()}, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
